// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-requester ROM burst arbiter.
package rom_arb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; ptr names the requester that wins a tie.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  req_idx_t ptr,
    output logic     valid,
    output req_idx_t pick
);

    always_comb begin
        valid = req0 | req1;
        pick  = REQ0;
        if (req0 && req1) begin
            pick = ptr;
        end else if (req1) begin
            pick = REQ1;
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one synchronous ROM between two burst requesters, round-robin,
// issuing one address per cycle and returning words two cycles later.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] start0,
    input  logic [ADDR_W-1:0] start1,
    input  logic [ADDR_W-1:0] len0,
    input  logic [ADDR_W-1:0] len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    req_idx_t          ptr;
    req_idx_t          owner;
    req_idx_t          pick;
    logic              pick_valid;
    logic              accept;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] sel_start;
    logic [ADDR_W-1:0] sel_len;
    logic              p1;
    logic              p1_last;

    rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
        .ptr   (ptr),
        .valid (pick_valid),
        .pick  (pick)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sel_start = (pick == REQ1) ? start1 : start0;
        sel_len   = (pick == REQ1) ? len1 : len0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (count == '0) begin
                    state_nxt = DRAIN;
                end
            end
            // The final issued word sits in stage one; it is captured at this edge.
            DRAIN: begin
                if (p1_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= REQ0;
            owner    <= REQ0;
            rom_addr <= '0;
            count    <= '0;
            p1       <= 1'b0;
            p1_last  <= 1'b0;
            rdata    <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
        end else begin
            gnt0    <= accept && (pick == REQ0);
            gnt1    <= accept && (pick == REQ1);
            // Stage one marks an address the ROM is sampling; stage two is the output.
            p1      <= (state == ISSUE);
            p1_last <= (state == ISSUE) && (count == '0);
            rvalid0 <= p1 && (owner == REQ0);
            rvalid1 <= p1 && (owner == REQ1);
            done0   <= p1_last && (owner == REQ0);
            done1   <= p1_last && (owner == REQ1);
            if (p1) begin
                rdata <= rom_data;
            end
            if (accept) begin
                rom_addr <= sel_start;
                count    <= sel_len;
                owner    <= pick;
                ptr      <= (pick == REQ0) ? REQ1 : REQ0;
            end else if ((state == ISSUE) && (count != '0)) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                count    <= count - ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Randomized and directed bench for rom_burst_arbiter with a cycle-schedule reference model.
module tb_rom_burst_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int NW   = 1 << AW;
    localparam int SLOT = 64;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          req0   = 1'b0;
    logic          req1   = 1'b0;
    logic [AW-1:0] start0 = '0;
    logic [AW-1:0] start1 = '0;
    logic [AW-1:0] len0   = '0;
    logic [AW-1:0] len1   = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, done0, done1;
    logic [DW-1:0] rdata;
    logic [DW-1:0] rom_data;
    logic [AW-1:0] rom_addr;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = -1;
    bit keep0    = 1'b0;

    rom_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .start0   (start0),
        .start1   (start1),
        .len0     (len0),
        .len1     (len1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .done0    (done0),
        .done1    (done1),
        .rdata    (rdata),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        case (a)
            4'd0:    return 16'h5601;
            4'd1:    return 16'h3401;
            4'd2:    return 16'h1801;
            4'd3:    return 16'h2A02;
            4'd4:    return 16'h7F10;
            4'd5:    return 16'h0C33;
            4'd6:    return 16'h4E21;
            4'd7:    return 16'h1B7A;
            4'd8:    return 16'h6D05;
            4'd9:    return 16'h3801;
            4'd10:   return 16'h2F44;
            4'd11:   return 16'h0919;
            4'd12:   return 16'h7710;
            4'd13:   return 16'h1234;
            4'd14:   return 16'h5601;
            default: return 16'h5401;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    // Reference: each accept schedules gnt, per-cycle addresses, words and done by arithmetic.
    logic [1:0]    s_gnt  [SLOT];
    logic [1:0]    s_rv   [SLOT];
    logic [1:0]    s_done [SLOT];
    logic [DW-1:0] s_data [SLOT];
    logic          s_aset [SLOT];
    logic [AW-1:0] s_addr [SLOT];
    int            next_free = 0;
    int            m_ptr     = 0;
    logic [5:0]    exp_ctrl  = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic [AW-1:0] exp_addr  = '0;
    bit            model_live = 1'b0;

    always @(posedge clk) begin
        int slot, pick, st, ln, nl;
        cyc  = cyc + 1;
        slot = cyc % SLOT;
        if (rst) begin
            for (int i = 0; i < SLOT; i++) begin
                s_gnt[i]  = 2'd0;
                s_rv[i]   = 2'd0;
                s_done[i] = 2'd0;
                s_data[i] = '0;
                s_aset[i] = 1'b0;
                s_addr[i] = '0;
            end
            next_free = cyc + 1;
            m_ptr     = 0;
            exp_ctrl  = '0;
            exp_rdata = '0;
            exp_addr  = '0;
        end else begin
            if (cyc >= next_free && (req0 || req1)) begin
                pick  = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
                m_ptr = 1 - pick;
                st    = pick ? int'(start1) : int'(start0);
                ln    = pick ? int'(len1) : int'(len0);
                nl    = ln + 1;
                s_gnt[slot] = 2'(pick + 1);
                for (int k = 0; k < nl; k++) begin
                    s_aset[(cyc + k) % SLOT]     = 1'b1;
                    s_addr[(cyc + k) % SLOT]     = AW'((st + k) % NW);
                    s_rv[(cyc + k + 2) % SLOT]   = 2'(pick + 1);
                    s_data[(cyc + k + 2) % SLOT] = rom_word(AW'((st + k) % NW));
                end
                s_done[(cyc + nl + 1) % SLOT] = 2'(pick + 1);
                next_free = cyc + nl + 2;
            end
            exp_ctrl = {s_gnt[slot] == 2'd1, s_gnt[slot] == 2'd2,
                        s_rv[slot] == 2'd1, s_rv[slot] == 2'd2,
                        s_done[slot] == 2'd1, s_done[slot] == 2'd2};
            if (s_aset[slot]) exp_addr = s_addr[slot];
            if (s_rv[slot] != 2'd0) exp_rdata = s_data[slot];
            s_gnt[slot]  = 2'd0;
            s_rv[slot]   = 2'd0;
            s_done[slot] = 2'd0;
            s_aset[slot] = 1'b0;
        end
        model_live = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, done0, done1}), 32'(exp_ctrl));
            checkOutput("rdata", 32'(rdata), 32'(exp_rdata));
            checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (gnt0 && !keep0) req0 = 1'b0;
        if (gnt1) req1 = 1'b0;
    endtask

    task automatic applyStimulus(input int which, input int st, input int ln);
        if (which == 0) begin
            req0   = 1'b1;
            start0 = AW'(st);
            len0   = AW'(ln);
        end else begin
            req1   = 1'b1;
            start1 = AW'(st);
            len1   = AW'(ln);
        end
    endtask

    task automatic waitQuiet();
        int budget;
        budget = 200;
        while ((req0 || req1) && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("req_released", 32'({req0, req1}), 32'(0));
        repeat (20) tick();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        applyStimulus(0, 0, 2);
        waitQuiet();
        applyStimulus(1, 14, 3);
        waitQuiet();

        // Contention straight out of reset, then repeated pairs.
        rst = 1'b1;
        applyStimulus(0, 1, 1);
        applyStimulus(1, 4, 2);
        tick();
        rst = 1'b0;
        waitQuiet();
        repeat (3) begin
            applyStimulus(0, 7, 1);
            applyStimulus(1, 10, 0);
            waitQuiet();
        end

        // Full burst with requests wiggling while busy.
        applyStimulus(0, 5, 15);
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            req1 = i[0];
            req0 = ~i[0];
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (20) tick();

        // Reset at the second word of a len=7 burst.
        applyStimulus(0, 3, 7);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        applyStimulus(1, 9, 0);
        waitQuiet();

        // Back-to-back single-word bursts with req0 held.
        keep0 = 1'b1;
        applyStimulus(0, 2, 0);
        for (int i = 0; i < 15; i++) begin
            start0 = AW'($urandom_range(0, NW - 1));
            tick();
        end
        keep0 = 1'b0;
        req0  = 1'b0;
        repeat (20) tick();

        for (int i = 0; i < 400; i++) begin
            if (!req0 && $urandom_range(0, 3) == 0)
                applyStimulus(0, int'($urandom_range(0, NW - 1)), int'($urandom_range(0, NW - 1)));
            if (!req1 && $urandom_range(0, 3) == 0)
                applyStimulus(1, int'($urandom_range(0, NW - 1)), int'($urandom_range(0, NW - 1)));
            if ($urandom_range(0, 15) == 0) begin
                start0 = AW'($urandom_range(0, NW - 1));
                len1   = AW'($urandom_range(0, NW - 1));
            end
            if ($urandom_range(0, 31) == 0) req1 = 1'b0;
            if ($urandom_range(0, 149) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (20) tick();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_burst_arbiter.md
# rom_burst_arbiter

Shares the 16×16 synchronous `ROM` between two requesters. Each requester asks for a burst of 1–16 consecutive words. Bursts are granted round-robin and issued to the ROM at one address per cycle. The block sits between the `ROM` instance (it drives `rom_addr`, consumes `rom_data`) and two client blocks, such as a tone sequencer and a table loader.

## Interface
Parameters:
- `ADDR_W`, 4, ROM address width; bursts wrap modulo 2^ADDR_W.
- `DATA_W`, 16, ROM word width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  burst request, level; held until the matching `gnt`.
- `start0`, `start1`  in  ADDR_W  first word address; sampled only at the accept edge.
- `len0`, `len1`  in  ADDR_W  burst length minus one (0 → 1 word, 15 → 16 words); sampled only at the accept edge.
- `gnt0`, `gnt1`  out  1  one-cycle pulse, high in the cycle after the accept edge.
- `rvalid0`, `rvalid1`  out  1  `rdata` carries a word of that requester's burst.
- `done0`, `done1`  out  1  high together with the last `rvalid` of the burst.
- `rdata`  out  DATA_W  shared read data; holds its last value when no `rvalid` is high.
- `rom_addr`  out  ADDR_W  registered address to `ROM.addr`.
- `rom_data`  in  DATA_W  from `ROM.out`; valid one edge after `rom_addr` is sampled.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: at an edge with any `req` high, accept one request:
  - load `rom_addr` ← start;
  - set count ← len;
  - record the owner;
  - pulse that requester's `gnt`;
  - go to ISSUE.
- Arbitration:
  - Single request: grant it.
  - Both requests: grant the requester not served last.
  - The priority pointer resets to favour requester 0 and is updated at every accept.
- ISSUE: each edge, if count ≠ 0, `rom_addr` ← `rom_addr`+1 (mod 2^ADDR_W) and count ← count−1. If count = 0, go to DRAIN.
- DRAIN: wait until the last issued word is captured, then go to IDLE.
- Capture:
  - A 2-stage valid pipeline tracks issued addresses.
  - When a word emerges, `rdata` ← `rom_data` and the owner's `rvalid` is set.
  - `done` is set with the final word.
- `req` is ignored outside IDLE. A `req` still high when IDLE is re-entered is a new burst, so requesters drop `req` in their `gnt` cycle.
- Exactly one of `rvalid0`/`rvalid1` is high at a time; both are never high together.

## Timing
- Burst of L = len+1 words accepted at edge E0:
  - `gnt` is high during cycle E0→E0+1.
  - `rom_addr` = start+k during cycle E0+k→E0+k+1.
  - Word k (ROM[start+k]) appears on `rdata`, with `rvalid`, in cycle E0+k+2→E0+k+3, for k = 0..L−1.
  - `done` is high in cycle E0+L+1→E0+L+2.
- Throughput is one word per cycle within a burst.
- IDLE is entered at edge E0+L+1. The earliest next accept is edge E0+L+2, so the per-burst cost is L+2 cycles.
- Address wraps: start=14, len=3 reads addresses 14, 15, 0, 1.
- Reset values: state IDLE, pointer → requester 0, `rom_addr`=0, `rdata`=0, all `gnt`/`rvalid`/`done`=0, count=0.
- Reset mid-burst:
  - In-flight words are discarded.
  - No `rvalid` or `done` is asserted in the cycle after the reset edge.
  - The first accept is possible at the first edge with `rst` low.

## Structure
- Shared package `rom_arb_pkg`:
  - state enum (IDLE/ISSUE/DRAIN);
  - `ADDR_W`/`DATA_W` defaults;
  - requester index type.
- Sub-module `rr_arb2`: combinational two-way round-robin pick, with the pointer register held in the parent.
- The `ROM` instance lives outside this block. The testbench instantiates both.

## Test plan
- Single burst: req0 with start=0, len=2.
  - `gnt0` pulses once.
  - `rvalid0` is high for 3 consecutive cycles with `rdata` = 16'h5601, 16'h3401, 16'h1801.
  - `done0` is high on the 16'h1801 word.
  - Total of 4 cycles accept → IDLE.
- Wrap: req1 with start=14, len=3.
  - `rdata` = 16'h5601, 16'h5401, 16'h5601, 16'h3401 on `rvalid1`.
  - `done1` is high on the 4th word.
- Contention: req0 and req1 both high out of reset.
  - Requester 0 is granted first.
  - Requester 1 is granted at the first IDLE edge after `done0`.
  - Repeating both requests alternates grants 1, 0, 1.
- Full burst: len=15, start=5.
  - 16 words read from addresses 5..15 then 0..4.
  - `done` is high only on the 16th word.
  - `req` toggled during ISSUE/DRAIN produces no extra `gnt`.
- Reset mid-burst: assert `rst` for one cycle at the 2nd word of a len=7 burst.
  - All outputs are 0 the next cycle and no further `rvalid` appears.
  - A new req1 with start=9, len=0 then returns 16'h3801 two cycles after its accept edge.
- Back-to-back: req0 held continuously with len=0.
  - Grants recur every 3 cycles.
  - `rdata` tracks ROM[start] each time.
